// File: rtl/event_debouncer.sv
// Multi-channel debounced event detector: synchroniser, stability counter and rise/fall/both event pulses per channel.
// Optional sticky event flags and any_event are built only when DEBOUNCE_STICKY_EN is defined.
module event_debouncer #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy_in,
  input  logic [CNT_W-1:0]    hold_cycles,
  input  logic [1:0]          edge_mode,
  input  logic [CHANNELS-1:0] sticky_clear,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] event_pulse,
  output logic [CHANNELS-1:0] event_sticky,
  output logic                any_event
);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } edge_mode_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  edge_mode_e mode;
  assign mode = edge_mode_e'(edge_mode);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic                   level_q, level_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   pulse_q, pulse_d;

      assign s = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q  <= '0;
          level_q <= 1'b0;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end else begin
          sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy_in[gi]};
          level_q <= level_d;
          cnt_q   <= cnt_d;
          pulse_q <= pulse_d;
        end
      end

      // cnt holds the number of consecutive earlier cycles s disagreed with level
      always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (s == level_q) begin
          cnt_d = '0;
        end else if (cnt_q >= hold_cycles) begin
          level_d = s;
          cnt_d   = '0;
          case (mode)
            MODE_RISE: pulse_d = s;
            MODE_FALL: pulse_d = ~s;
            MODE_BOTH: pulse_d = 1'b1;
            default:   pulse_d = 1'b0;
          endcase
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      assign level_out[gi]   = level_q;
      assign event_pulse[gi] = pulse_q;
    end
  endgenerate

`ifdef DEBOUNCE_STICKY_EN
  logic [CHANNELS-1:0] sticky_q;

  // A new pulse overrides a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~sticky_clear) | event_pulse;
    end
  end

  assign event_sticky = sticky_q;
  assign any_event    = |sticky_q;
`else
  logic unused_sticky_clear;
  assign unused_sticky_clear = ^sticky_clear;
  assign event_sticky        = '0;
  assign any_event           = 1'b0;
`endif

endmodule

// File: tb/tb_event_debouncer.sv
// Randomised bench for event_debouncer against a history-based reference model.
// Honours DEBOUNCE_STICKY_EN the same way the design does.
module tb_event_debouncer;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy_in;
  logic [CW-1:0] hold_cycles;
  logic [1:0]    edge_mode;
  logic [CH-1:0] sticky_clear;
  logic [CH-1:0] level_out;
  logic [CH-1:0] event_pulse;
  logic [CH-1:0] event_sticky;
  logic          any_event;

  event_debouncer #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .noisy_in(noisy_in), .hold_cycles(hold_cycles),
    .edge_mode(edge_mode), .sticky_clear(sticky_clear), .level_out(level_out),
    .event_pulse(event_pulse), .event_sticky(event_sticky), .any_event(any_event)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: input samples and history of synchronised values per channel.
  // A change is accepted once the most recent H+1 synchronised samples all differ from level.
  bit m_samp[CH][$];
  bit m_shist[CH][$];
  bit m_lvl[CH];
  bit m_pulse[CH];
  bit m_sticky[CH];

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_samp[i].delete();
      m_shist[i].delete();
      m_lvl[i]    = 1'b0;
      m_pulse[i]  = 1'b0;
      m_sticky[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < CH; i++) begin
      bit s;
      int n;
      bit old_pulse;
      old_pulse = m_pulse[i];
      s = (m_samp[i].size() >= SS) ? m_samp[i][m_samp[i].size() - SS] : 1'b0;
      m_samp[i].push_back(noisy_in[i]);
      if (m_samp[i].size() > 16) void'(m_samp[i].pop_front());
      m_shist[i].push_back(s);
      if (m_shist[i].size() > 64) void'(m_shist[i].pop_front());
      n = 0;
      for (int j = m_shist[i].size() - 1; j >= 0; j--) begin
        if (m_shist[i][j] == m_lvl[i]) break;
        n++;
      end
      m_pulse[i] = 1'b0;
      if (n >= int'(hold_cycles) + 1) begin
        case (edge_mode)
          2'b00:   m_pulse[i] = s;
          2'b01:   m_pulse[i] = ~s;
          2'b10:   m_pulse[i] = 1'b1;
          default: m_pulse[i] = 1'b0;
        endcase
        m_lvl[i] = s;
      end
`ifdef DEBOUNCE_STICKY_EN
      m_sticky[i] = (m_sticky[i] & ~sticky_clear[i]) | old_pulse;
`else
      m_sticky[i] = 1'b0;
`endif
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // Wait for the falling edge, then compare every output against the model.
  task automatic tick();
    logic [CH-1:0] e_lvl, e_pulse, e_sticky;
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      e_lvl[i]    = m_lvl[i];
      e_pulse[i]  = m_pulse[i];
      e_sticky[i] = m_sticky[i];
    end
    $display("t=%0t in=%b H=%0d mode=%b clr=%b lvl=%b pulse=%b sticky=%b any=%b",
             $time, noisy_in, hold_cycles, edge_mode, sticky_clear,
             level_out, event_pulse, event_sticky, any_event);
    check_val("level_out", 32'(level_out), 32'(e_lvl));
    check_val("event_pulse", 32'(event_pulse), 32'(e_pulse));
    check_val("event_sticky", 32'(event_sticky), 32'(e_sticky));
    check_val("any_event", 32'(any_event), 32'(|e_sticky));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Ticks until level_out[ch] equals want; returns the tick count or 0 on timeout.
  task automatic measure(input int ch, input bit want, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (lat == 0 && level_out[ch] == want) lat = k;
    end
  endtask

  int lat;

  initial begin
    reset        = 1'b1;
    noisy_in     = '0;
    hold_cycles  = 8'd3;
    edge_mode    = 2'b00;
    sticky_clear = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("reset_level", 32'(level_out), 32'd0);
    check_val("reset_pulse", 32'(event_pulse), 32'd0);
    reset = 1'b0;

    // Clean rise on ch0: accepted on the sixth edge
    noisy_in[0] = 1'b1;
    measure(0, 1'b1, lat);
    check_val("rise_latency", 32'(lat), 32'd6);

    // Glitch of 3 cycles rejected, 4 cycles accepted on ch1
    noisy_in[1] = 1'b1; ticks(3); noisy_in[1] = 1'b0; ticks(10);
    check_val("glitch3_rejected", 32'(level_out[1]), 32'd0);
    noisy_in[1] = 1'b1; ticks(4); noisy_in[1] = 1'b0; ticks(10);

    // Fall mode on ch2, then events disabled
    edge_mode = 2'b01;
    noisy_in[2] = 1'b1; ticks(10); noisy_in[2] = 1'b0; ticks(10);
    edge_mode = 2'b11;
    noisy_in[2] = 1'b1; ticks(10); noisy_in[2] = 1'b0; ticks(10);

    // Both edges with H=0 on ch3
    edge_mode = 2'b10; hold_cycles = 8'd0;
    noisy_in[3] = 1'b1;
    measure(3, 1'b1, lat);
    check_val("h0_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 6; k++) begin
      noisy_in[3] = ~noisy_in[3];
      ticks(4);
    end

    // Sticky set and clear in the same cycle: set wins, then clear
    edge_mode = 2'b10; hold_cycles = 8'd3;
    noisy_in[0] = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && lat == 0; k++) begin
      tick();
      if (event_pulse[0]) lat = k + 1;
    end
    check_val("sticky_pulse_seen", 32'(lat != 0), 32'd1);
    sticky_clear[0] = 1'b1; tick();
    tick();
    sticky_clear[0] = 1'b0; ticks(3);

    // Reset mid-count with input held high
    edge_mode = 2'b00; noisy_in = '0; ticks(12);
    noisy_in[0] = 1'b1; ticks(4);
    #2 reset = 1'b1;
    #1;
    check_val("midreset_level", 32'(level_out), 32'd0);
    check_val("midreset_pulse", 32'(event_pulse), 32'd0);
    check_val("midreset_sticky", 32'(event_sticky), 32'd0);
    check_val("midreset_any", 32'(any_event), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    measure(0, 1'b1, lat);
    check_val("post_reset_latency", 32'(lat), 32'd6);

    // Randomised segments with mid-run parameter changes
    for (int seg = 0; seg < 30; seg++) begin
      hold_cycles = 8'($urandom_range(0, 5));
      edge_mode   = 2'($urandom_range(0, 3));
      for (int c = 0; c < 40; c++) begin
        for (int i = 0; i < CH; i++) begin
          if ($urandom_range(0, 5) == 0) noisy_in[i] = ~noisy_in[i];
          sticky_clear[i] = ($urandom_range(0, 3) == 0);
        end
        if ($urandom_range(0, 19) == 0) hold_cycles = 8'($urandom_range(0, 5));
        if ($urandom_range(0, 19) == 0) edge_mode = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/event_debouncer.md
# event_debouncer

Multi-channel debounced event detector with a synchroniser, a per-channel stability counter, a selectable edge mode and optional sticky event flags. It turns raw asynchronous inputs (buttons, sensor strobes) into clean one-cycle event pulses. It generalises the single-bit rising-edge denoiser by adding channel count, a glitch-rejection window and rise/fall/both selection.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- CNT_W, 8, width of stability counter and `hold_cycles`
- SYNC_STAGES, 2, flip-flops in each input synchroniser (≥2)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- noisy_in  in  CHANNELS  raw asynchronous inputs
- hold_cycles  in  CNT_W  stability threshold H, quasi-static, shared by all channels
- edge_mode  in  2  00 rise, 01 fall, 10 both, 11 events disabled
- sticky_clear  in  CHANNELS  per-channel clear of `event_sticky`
- level_out  out  CHANNELS  debounced level
- event_pulse  out  CHANNELS  one-cycle event strobe
- event_sticky  out  CHANNELS  latched event flags
- any_event  out  1  OR of `event_sticky`

## Operation
- Each channel passes through a SYNC_STAGES flop chain. `s` is the last stage.
- Each channel has a stable `level` register and a counter `cnt` (CNT_W bits). Per clock:
  - If `s == level`: `cnt <= 0`.
  - Else if `cnt >= hold_cycles`: `level <= s` and `cnt <= 0`. This is a level update.
  - Else: `cnt <= cnt + 1`, saturating at all-ones.
- An input change must persist for H+1 consecutive synchronised cycles to be accepted. Runs of H cycles or fewer are discarded, and `cnt` restarts from 0.
- With H = 0, `level` follows `s` one cycle later.
- `event_pulse[i]` is registered and set on the same edge as a level update when the update matches `edge_mode`:
  - rise: 0→1
  - fall: 1→0
  - both: either direction
  - 11: never
- Otherwise `event_pulse[i]` is 0. It is never wider than one cycle.
- `hold_cycles` and `edge_mode` are sampled every cycle. A change mid-count applies immediately with no reset of `cnt`.
- Channels are fully independent. Simultaneous events on several channels all pulse.

## Timing
- Reset values: synchroniser flops, `level`, `cnt`, `level_out`, `event_pulse`, `event_sticky` and `any_event` are all 0. Reset takes effect immediately, including mid-count.
- After reset, an input already held high is treated as a 0→1 change. It produces a rise event after the normal latency.
- Latency from `noisy_in` change (set up before edge 1) to `level_out` and `event_pulse` asserted: SYNC_STAGES + H + 1 edges.
- `level_out` and `event_pulse` change on the same edge.
- `event_sticky[i]` sets on the edge after `event_pulse[i]` is high. It clears on the edge after `sticky_clear[i]` is high.
- If set and clear occur in the same cycle, set wins.
- `any_event` is combinational OR of `event_sticky`.

## Configuration
- Macro: `DEBOUNCE_STICKY_EN`.
- Defined: sticky flags and `any_event` behave as described above.
- Undefined:
  - No sticky registers are built.
  - `event_sticky` and `any_event` are tied to 0.
  - `sticky_clear` is ignored.
  - `level_out` and `event_pulse` are unchanged.

## Test plan
All scenarios use CHANNELS=4, CNT_W=8, SYNC_STAGES=2, H=3, mode 00 unless stated.
- Clean rise, ch0 high before edge 1 → `level_out[0]`=1 and `event_pulse[0]`=1 after edge 6; pulse drops after edge 7; other channels stay 0.
- Glitch, ch1 high for 3 cycles then low → no `level_out` change and no pulse. Repeat with a 4-cycle high → rise accepted at edge 6.
- Mode 01: rise then fall on ch2, each held 10 cycles → `level_out[2]` toggles both times; only the fall produces `event_pulse[2]`. Mode 11 → no pulses at all.
- Mode 10, H=0: ch3 toggles every 4 cycles → one pulse per transition, each at latency 3, `level_out` tracks the toggle.
- Sticky (macro defined): event on ch0 with `sticky_clear[0]`=1 in the same cycle → `event_sticky[0]`=1 and `any_event`=1. Clear on the next cycle → both 0. Macro undefined → both always 0.
- Reset with ch0 `cnt`=2 → all outputs 0 immediately. After release with input still high → rise event 6 edges later.
